// File: rtl/wave_bank_loader.sv
// Wave-table loader: streams samples from source memory into one of NUM_BANKS
// on-chip tables and serves round-robin oscillator playback. Optional macro:
// WAVE_BANK_LOADER_GATE_OFF_EN forces playback of disabled oscillators to zero.
module wave_bank_loader #(
  parameter  int NUM_OSCILLATORS = 4,
  parameter  int SAMPLE_WIDTH    = 16,
  parameter  int WW_WIDTH        = 10,
  parameter  int NUM_BANKS       = 2,
  parameter  int SRC_AW          = 18,
  localparam int BW              = $clog2(NUM_BANKS)
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  load_trig_in,
  input  logic [BW-1:0]                         load_bank_in,
  input  logic [WW_WIDTH:0]                     wave_width_in,
  input  logic [SRC_AW-1:0]                     src_base_in,
  output logic [SRC_AW-1:0]                     src_addr_out,
  output logic                                  src_req_out,
  input  logic [SAMPLE_WIDTH-1:0]               src_data_in,
  input  logic                                  src_valid_in,
  output logic                                  busy_out,
  output logic                                  done_out,
  input  logic [NUM_OSCILLATORS-1:0]            osc_is_on_in,
  input  logic [NUM_OSCILLATORS*BW-1:0]         osc_bank_in,
  input  logic [NUM_OSCILLATORS*WW_WIDTH-1:0]   osc_index_in,
  output logic [NUM_OSCILLATORS*SAMPLE_WIDTH-1:0] osc_data_out
);

  localparam int SLW   = $clog2(NUM_OSCILLATORS);
  localparam int AW    = BW + WW_WIDTH;
  localparam int DEPTH = NUM_BANKS * (2 ** WW_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WRITE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic           valid;
    logic [SLW-1:0] slot;
    logic [BW-1:0]  bank;
    logic           kill;
    logic           hold;
  } tag_t;

  state_e                  state_q, state_d;
  logic [WW_WIDTH:0]       n_q, n_d;
  logic [WW_WIDTH:0]       len_q, len_d;
  logic [WW_WIDTH:0]       n_inc;
  logic [BW-1:0]           bank_q, bank_d;
  logic [SRC_AW-1:0]       base_q, base_d;
  logic [SAMPLE_WIDTH-1:0] wdata_q, wdata_d;
  logic [WW_WIDTH:0]       width_q [NUM_BANKS];
  logic [WW_WIDTH:0]       width_d [NUM_BANKS];
  logic                    busy;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;

  logic [SLW-1:0]          slot_q, slot_d;
  logic [BW-1:0]           sel_bank;
  logic [WW_WIDTH-1:0]     sel_index;
  logic [WW_WIDTH:0]       sel_width;
  logic                    sel_off;
  logic [AW-1:0]           rd_addr_q, rd_addr_d;
  tag_t                    p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic                    upd_hold;
  logic [NUM_OSCILLATORS*SAMPLE_WIDTH-1:0] osc_data_q, osc_data_d;

  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
  logic [SAMPLE_WIDTH-1:0] ram_rd_q;
  logic [SAMPLE_WIDTH-1:0] ram_out_q;

  assign busy         = (state_q != ST_IDLE);
  assign busy_out     = busy;
  assign src_req_out  = (state_q == ST_REQ);
  assign done_out     = (state_q == ST_DONE);
  assign src_addr_out = (state_q == ST_REQ) ? base_q + SRC_AW'(n_q) : '0;
  assign n_inc        = n_q + (WW_WIDTH + 1)'(1);
  assign osc_data_out = osc_data_q;

  // Load FSM
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    len_d   = len_q;
    bank_d  = bank_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    width_d = width_q;
    wr_en   = 1'b0;
    wr_addr = {bank_q, n_q[WW_WIDTH-1:0]};
    case (state_q)
      ST_IDLE: begin
        if (load_trig_in) begin
          bank_d  = load_bank_in;
          len_d   = wave_width_in;
          base_d  = src_base_in;
          n_d     = '0;
          state_d = (wave_width_in == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (src_valid_in) begin
          wdata_d = src_data_in;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_en = (int'(bank_q) < NUM_BANKS);
        if (n_inc == len_q) begin
          state_d = ST_DONE;
        end else begin
          n_d     = n_inc;
          state_d = ST_REQ;
        end
      end
      ST_DONE: begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
          if (bank_q == BW'(b)) width_d[b] = len_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Slot selection: pick this slot's oscillator inputs and bank width
  always_comb begin
    sel_bank  = '0;
    sel_index = '0;
    sel_width = '0;
    sel_off   = 1'b0;
    for (int unsigned k = 0; k < NUM_OSCILLATORS; k++) begin
      if (slot_q == SLW'(k)) begin
        sel_bank  = osc_bank_in[k*BW +: BW];
        sel_index = osc_index_in[k*WW_WIDTH +: WW_WIDTH];
`ifdef WAVE_BANK_LOADER_GATE_OFF_EN
        sel_off   = ~osc_is_on_in[k];
`endif
      end
    end
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (sel_bank == BW'(b)) sel_width = width_q[b];
    end
  end

`ifndef WAVE_BANK_LOADER_GATE_OFF_EN
  logic unused_is_on;
  assign unused_is_on = ^osc_is_on_in;
`endif

  // Playback pipeline: sample -> RAM stage 1 -> RAM stage 2 -> output register.
  // Hold is checked at sample and again at update so a load that starts
  // mid-flight still freezes the oscillator.
  always_comb begin
    slot_d     = (slot_q == SLW'(NUM_OSCILLATORS - 1)) ? '0 : slot_q + SLW'(1);
    rd_addr_d  = {sel_bank, sel_index};
    p1_d.valid = 1'b1;
    p1_d.slot  = slot_q;
    p1_d.bank  = sel_bank;
    p1_d.kill  = ({1'b0, sel_index} >= sel_width) | sel_off;
    p1_d.hold  = busy && (bank_q == sel_bank);
    p2_d       = p1_q;
    p3_d       = p2_q;
    upd_hold   = p3_q.hold || (busy && (bank_q == p3_q.bank));
    osc_data_d = osc_data_q;
    if (p3_q.valid && !upd_hold) begin
      for (int unsigned k = 0; k < NUM_OSCILLATORS; k++) begin
        if (p3_q.slot == SLW'(k)) begin
          osc_data_d[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = p3_q.kill ? '0 : ram_out_q;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      len_q      <= '0;
      bank_q     <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) width_q[b] <= '0;
      slot_q     <= '0;
      rd_addr_q  <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      p3_q       <= '0;
      osc_data_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      len_q      <= len_d;
      bank_q     <= bank_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      width_q    <= width_d;
      slot_q     <= slot_d;
      rd_addr_q  <= rd_addr_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      p3_q       <= p3_d;
      osc_data_q <= osc_data_d;
    end
  end

  // Table storage: write port A, registered two-stage read port B, never reset
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wdata_q;
    ram_rd_q  <= mem[rd_addr_q];
    ram_out_q <= ram_rd_q;
  end

endmodule

// File: tb/tb_wave_bank_loader.sv
// Scoreboard bench for wave_bank_loader: source-request addresses and
// playback samples are queued as expectations and compared on DUT output.
module tb_wave_bank_loader;
  localparam int N   = 4;
  localparam int SW  = 16;
  localparam int WW  = 10;
  localparam int NB  = 2;
  localparam int SAW = 18;
  localparam int BW  = 1;
  localparam int SETTLE = 3 * N + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_trig_in;
  logic [BW-1:0]     load_bank_in;
  logic [WW:0]       wave_width_in;
  logic [SAW-1:0]    src_base_in;
  logic [SAW-1:0]    src_addr_out;
  logic              src_req_out;
  logic [SW-1:0]     src_data_in;
  logic              src_valid_in;
  logic              busy_out;
  logic              done_out;
  logic [N-1:0]      osc_is_on_in;
  logic [N*BW-1:0]   osc_bank_in;
  logic [N*WW-1:0]   osc_index_in;
  logic [N*SW-1:0]   osc_data_out;

  int errors = 0;
  int checks = 0;
  int slot_m;
  int osc0_changes;
  int hold_bad;
  logic [SAW-1:0] exp_addr_q[$];
  logic [SAW-1:0] seen_addr_q[$];
  logic [SW-1:0]  play_q[$];

  always #5 clk = ~clk;

  wave_bank_loader #(
    .NUM_OSCILLATORS(N),
    .SAMPLE_WIDTH(SW),
    .WW_WIDTH(WW),
    .NUM_BANKS(NB),
    .SRC_AW(SAW)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .load_trig_in(load_trig_in),
    .load_bank_in(load_bank_in),
    .wave_width_in(wave_width_in),
    .src_base_in(src_base_in),
    .src_addr_out(src_addr_out),
    .src_req_out(src_req_out),
    .src_data_in(src_data_in),
    .src_valid_in(src_valid_in),
    .busy_out(busy_out),
    .done_out(done_out),
    .osc_is_on_in(osc_is_on_in),
    .osc_bank_in(osc_bank_in),
    .osc_index_in(osc_index_in),
    .osc_data_out(osc_data_out)
  );

  // Independent slot tracker: value seen at a falling edge is the slot sampled next
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_m <= 0;
    else slot_m <= (slot_m == N - 1) ? 0 : slot_m + 1;
  end

  function automatic logic [SW-1:0] src_word(input logic [SAW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  function automatic logic [SW-1:0] osc(input int k);
    return osc_data_out[k*SW +: SW];
  endfunction

  task automatic set_osc(input int k, input logic bank, input int idx);
    osc_bank_in[k] = bank;
    osc_index_in[k*WW +: WW] = WW'(idx);
  endtask

  task automatic settle();
    repeat (SETTLE) @(negedge clk);
  endtask

  // Source memory model: answers each request two cycles after it appears
  initial begin
    int age;
    age = 0;
    src_valid_in = 1'b0;
    src_data_in  = '0;
    forever begin
      @(negedge clk);
      src_valid_in = 1'b0;
      if (rst_n === 1'b1 && src_req_out === 1'b1) begin
        if (age == 0) seen_addr_q.push_back(src_addr_out);
        age++;
        if (age == 2) begin
          src_valid_in = 1'b1;
          src_data_in  = src_word(src_addr_out);
          age = 0;
        end
      end else begin
        age = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic run_load(input logic bnk, input int width, input logic [SAW-1:0] base,
                          input bit mid_trig, input bit sweep0, input bit watch1,
                          input logic [SW-1:0] hold1);
    int done_cnt;
    int c;
    bit finished;
    logic [SW-1:0] prev0;
    logic [SAW-1:0] a, s;
    seen_addr_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < width; i++) exp_addr_q.push_back(base + SAW'(i));
    @(negedge clk);
    load_trig_in  = 1'b1;
    load_bank_in  = bnk;
    wave_width_in = (WW + 1)'(width);
    src_base_in   = base;
    @(negedge clk);
    load_trig_in  = 1'b0;
    done_cnt = 0;
    finished = 1'b0;
    osc0_changes = 0;
    hold_bad = 0;
    prev0 = osc(0);
    for (c = 0; c < 1000 && !finished; c++) begin
      if (done_out === 1'b1) begin
        done_cnt++;
      end else if (done_cnt > 0) begin
        checks++;
        if (busy_out !== 1'b0) begin
          errors++;
          $display("FAIL busy_after_done: got %b required 0", busy_out);
        end
        finished = 1'b1;
      end
      if (watch1 && busy_out === 1'b1 && osc(1) !== hold1) hold_bad++;
      if (osc(0) !== prev0) osc0_changes++;
      prev0 = osc(0);
      if (sweep0) osc_index_in[0 +: WW] = WW'(c % 8);
      if (mid_trig && c == 5) begin
        load_trig_in  = 1'b1;
        load_bank_in  = ~bnk;
        wave_width_in = 11'd3;
        src_base_in   = 18'h03000;
      end
      if (mid_trig && c == 6) load_trig_in = 1'b0;
      if (!finished) @(negedge clk);
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL load_timeout: got no completion required done within 1000 cycles");
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL done_pulse_count: got %0d required 1", done_cnt);
    end
    checks++;
    if (seen_addr_q.size() != width) begin
      errors++;
      $display("FAIL req_count: got %0d required %0d", seen_addr_q.size(), width);
    end
    while (exp_addr_q.size() > 0) begin
      a = exp_addr_q.pop_front();
      s = (seen_addr_q.size() > 0) ? seen_addr_q.pop_front() : 'x;
      checks++;
      if (s !== a) begin
        errors++;
        $display("FAIL req_addr: got %h required %h", s, a);
      end
    end
    seen_addr_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load_trig_in = 1'b0;
    load_bank_in = '0;
    wave_width_in = '0;
    src_base_in = '0;
    osc_is_on_in = '1;
    osc_bank_in = '0;
    osc_index_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({src_req_out, busy_out, done_out} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got req/busy/done=%b required 000", {src_req_out, busy_out, done_out});
    end
    checks++;
    if (src_addr_out !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %h required 0", src_addr_out);
    end
    checks++;
    if (osc_data_out !== '0) begin
      errors++;
      $display("FAIL reset_osc: got %h required 0", osc_data_out);
    end
    rst_n = 1'b1;
    settle();
    checks++;
    if (osc_data_out !== '0) begin
      errors++;
      $display("FAIL empty_banks_play_zero: got %h required 0", osc_data_out);
    end
  endtask

  task automatic test_load_basic();
    run_load(1'b0, 8, 18'h00100, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_playback();
    logic [SW-1:0] got, exp;
    int guard;
    set_osc(0, 1'b0, 0);
    play_q.push_back(src_word(18'h00100));
    settle();
    exp = play_q.pop_front();
    checks++;
    if (osc(0) !== exp) begin
      errors++;
      $display("FAIL play_idx0: got %h required %h", osc(0), exp);
    end
    checks++;
    if (osc(2) !== exp) begin
      errors++;
      $display("FAIL play_osc2_idx0: got %h required %h", osc(2), exp);
    end
    guard = 0;
    while (slot_m != 0 && guard < 2 * N) begin
      @(negedge clk);
      guard++;
    end
    set_osc(0, 1'b0, 3);
    play_q.push_back(src_word(18'h00103));
    repeat (3) @(negedge clk);
    checks++;
    if (osc(0) !== exp) begin
      errors++;
      $display("FAIL latency_early: got %h required %h", osc(0), exp);
    end
    @(negedge clk);
    got = osc(0);
    exp = play_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL latency_third_edge: got %h required %h", got, exp);
    end
    set_osc(0, 1'b0, 7);
    play_q.push_back(src_word(18'h00107));
    settle();
    exp = play_q.pop_front();
    checks++;
    if (osc(0) !== exp) begin
      errors++;
      $display("FAIL play_last_index: got %h required %h", osc(0), exp);
    end
    set_osc(0, 1'b0, 8);
    play_q.push_back('0);
    settle();
    exp = play_q.pop_front();
    checks++;
    if (osc(0) !== exp) begin
      errors++;
      $display("FAIL play_beyond_width: got %h required %h", osc(0), exp);
    end
    set_osc(0, 1'b0, 0);
  endtask

  task automatic test_busy_trigger();
    run_load(1'b0, 8, 18'h00100, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_hold();
    logic [SW-1:0] exp;
    run_load(1'b1, 8, 18'h00200, 1'b0, 1'b0, 1'b0, '0);
    set_osc(1, 1'b1, 2);
    play_q.push_back(src_word(18'h00202));
    settle();
    exp = play_q.pop_front();
    checks++;
    if (osc(1) !== exp) begin
      errors++;
      $display("FAIL play_bank1: got %h required %h", osc(1), exp);
    end
    run_load(1'b1, 8, 18'h00300, 1'b0, 1'b1, 1'b1, exp);
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL hold_during_load: got %0d changed cycles required 0", hold_bad);
    end
    checks++;
    if (osc0_changes == 0) begin
      errors++;
      $display("FAIL other_bank_updates: got %0d changes required >0", osc0_changes);
    end
    set_osc(0, 1'b0, 0);
    play_q.push_back(src_word(18'h00302));
    settle();
    exp = play_q.pop_front();
    checks++;
    if (osc(1) !== exp) begin
      errors++;
      $display("FAIL play_after_reload: got %h required %h", osc(1), exp);
    end
  endtask

  task automatic test_width_zero();
    int reqs;
    seen_addr_q.delete();
    @(negedge clk);
    load_trig_in  = 1'b1;
    load_bank_in  = 1'b1;
    wave_width_in = '0;
    src_base_in   = 18'h00400;
    @(negedge clk);
    checks++;
    if ({done_out, busy_out, src_req_out} !== 3'b110) begin
      errors++;
      $display("FAIL width0_done: got done/busy/req=%b required 110", {done_out, busy_out, src_req_out});
    end
    load_bank_in  = 1'b1;
    wave_width_in = 11'd4;
    src_base_in   = 18'h00600;
    @(negedge clk);
    load_trig_in = 1'b0;
    checks++;
    if ({done_out, busy_out} !== 2'b00) begin
      errors++;
      $display("FAIL width0_end: got done/busy=%b required 00", {done_out, busy_out});
    end
    reqs = 0;
    repeat (SETTLE) begin
      @(negedge clk);
      if (src_req_out !== 1'b0 || busy_out !== 1'b0) reqs++;
    end
    checks++;
    if (reqs != 0 || seen_addr_q.size() != 0) begin
      errors++;
      $display("FAIL trigger_in_done_ignored: got %0d active cycles required 0", reqs);
    end
    set_osc(3, 1'b1, 0);
    play_q.push_back('0);
    play_q.push_back('0);
    settle();
    checks++;
    if (osc(1) !== play_q.pop_front()) begin
      errors++;
      $display("FAIL width0_osc1: got %h required 0", osc(1));
    end
    checks++;
    if (osc(3) !== play_q.pop_front()) begin
      errors++;
      $display("FAIL width0_osc3: got %h required 0", osc(3));
    end
  endtask

  task automatic test_reset_mid_load();
    int guard;
    set_osc(0, 1'b0, 3);
    settle();
    checks++;
    if (osc(0) !== src_word(18'h00103)) begin
      errors++;
      $display("FAIL pre_reset_play: got %h required %h", osc(0), src_word(18'h00103));
    end
    @(negedge clk);
    load_trig_in  = 1'b1;
    load_bank_in  = 1'b0;
    wave_width_in = 11'd8;
    src_base_in   = 18'h00400;
    @(negedge clk);
    load_trig_in  = 1'b0;
    guard = 0;
    while (src_req_out !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (src_req_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_load_req: got %b required 1", src_req_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({src_req_out, busy_out, done_out} !== 3'b000 || src_addr_out !== '0) begin
      errors++;
      $display("FAIL async_reset_ctrl: got req/busy/done=%b addr=%h required 000 and 0",
               {src_req_out, busy_out, done_out}, src_addr_out);
    end
    checks++;
    if (osc_data_out !== '0) begin
      errors++;
      $display("FAIL async_reset_osc: got %h required 0", osc_data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_addr_q.delete();
    settle();
    checks++;
    if (osc(0) !== '0) begin
      errors++;
      $display("FAIL abandoned_bank: got %h required 0", osc(0));
    end
  endtask

  task automatic test_gate_off();
    logic [SW-1:0] exp;
    run_load(1'b0, 4, 18'h3FFFE, 1'b0, 1'b0, 1'b0, '0);
    set_osc(2, 1'b0, 1);
    osc_is_on_in[2] = 1'b0;
`ifdef WAVE_BANK_LOADER_GATE_OFF_EN
    play_q.push_back('0);
`else
    play_q.push_back(src_word(18'h3FFFF));
`endif
    settle();
    exp = play_q.pop_front();
    checks++;
    if (osc(2) !== exp) begin
      errors++;
      $display("FAIL gate_off_osc2: got %h required %h", osc(2), exp);
    end
    osc_is_on_in[2] = 1'b1;
    set_osc(2, 1'b0, 2);
    play_q.push_back(src_word(18'h00000));
    settle();
    exp = play_q.pop_front();
    checks++;
    if (osc(2) !== exp) begin
      errors++;
      $display("FAIL addr_wrap_play: got %h required %h", osc(2), exp);
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_playback();
    test_busy_trigger();
    test_hold();
    test_width_zero();
    test_reset_mid_load();
    test_gate_off();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_bank_loader.md
WAVE_BANK_LOADER -- requirements
Module: wave_bank_loader

Interface
REQ-001 Parameter NUM_OSCILLATORS, default 4: oscillator channels served round-robin; >=2.
REQ-002 Parameter SAMPLE_WIDTH, default 16: sample width in bits.
REQ-003 Parameter WW_WIDTH, default 10: per-table index width; table depth 2**WW_WIDTH.
REQ-004 Parameter NUM_BANKS, default 2: wave tables held on chip; >=2; BW = $clog2(NUM_BANKS).
REQ-005 Parameter SRC_AW, default 18: source-memory address width.
REQ-006 clk_in  input  1  single clock; all logic on rising edge.
REQ-007 rst_in  input  1  asynchronous active-low reset.
REQ-008 load_trig_in  input  1  one-cycle pulse that starts a table load.
REQ-009 load_bank_in  input  BW  destination bank, sampled on trigger.
REQ-010 wave_width_in  input  WW_WIDTH+1  sample count 0..2**WW_WIDTH, sampled on trigger.
REQ-011 src_base_in  input  SRC_AW  source start address, sampled on trigger.
REQ-012 src_addr_out  output  SRC_AW  source read address.
REQ-013 src_req_out  output  1  source read request.
REQ-014 src_data_in  input  SAMPLE_WIDTH  source read data.
REQ-015 src_valid_in  input  1  source data valid; completes the pending request.
REQ-016 busy_out  output  1  high while a load is in progress.
REQ-017 done_out  output  1  one-cycle pulse when a load completes.
REQ-018 osc_is_on_in  input  NUM_OSCILLATORS  per-oscillator enable.
REQ-019 osc_bank_in  input  NUM_OSCILLATORS x BW  per-oscillator bank select.
REQ-020 osc_index_in  input  NUM_OSCILLATORS x WW_WIDTH  per-oscillator playback index.
REQ-021 osc_data_out  output  NUM_OSCILLATORS x SAMPLE_WIDTH  per-oscillator registered sample.

Function
REQ-022 Storage SHALL be one dual-port RAM of NUM_BANKS*2**WW_WIDTH words at address {bank,index}; port A write-only for loading, port B read-only for playback, 2-cycle registered read latency.
REQ-023 Load FSM SHALL have states IDLE, REQ, WRITE, DONE; IDLE->REQ on load_trig_in with wave_width_in>0; IDLE->DONE on load_trig_in with wave_width_in==0.
REQ-024 In REQ, src_req_out=1 and src_addr_out=base+n; src_req_out SHALL hold until src_valid_in; src_valid_in in any other state SHALL be ignored.
REQ-025 REQ->WRITE on src_valid_in, capturing src_data_in; WRITE writes sample n to {bank,n}, then ->REQ with n+1, or ->DONE when n+1==width.
REQ-026 DONE SHALL last one cycle with done_out=1, commit the latched width into that bank's width register, then ->IDLE; busy_out=1 in REQ, WRITE and DONE.
REQ-027 load_trig_in SHALL be ignored while busy_out=1.
REQ-028 A 0..NUM_OSCILLATORS-1 slot counter SHALL advance every cycle and wrap; in slot k the block samples osc_index_in[k] and osc_bank_in[k] and issues a port-B read.
REQ-029 osc_data_out[k] SHALL update at the third rising edge after slot k is sampled and SHALL hold between updates; refresh period is NUM_OSCILLATORS cycles.
REQ-030 If osc_index_in[k] >= the width register of the selected bank, the update SHALL be 0.
REQ-031 If the selected bank is being loaded (busy_out=1, same bank), osc_data_out[k] SHALL hold its previous value; other banks play back unaffected.
REQ-032 Width registers are WW_WIDTH+1 bits; the source address SHALL wrap modulo 2**SRC_AW.

Reset
REQ-033 rst_in low SHALL immediately force FSM=IDLE, src_req_out=0, src_addr_out=0, busy_out=0, done_out=0, slot=0, all width registers=0, all osc_data_out=0.
REQ-034 Reset mid-load SHALL abandon the load; the bank is unusable (width 0) until reloaded; RAM contents are not cleared.

Configuration
REQ-035 With macro WAVE_BANK_LOADER_GATE_OFF_EN defined, an update for oscillator k with osc_is_on_in[k]=0 (sampled in its slot) SHALL write 0; undefined, osc_is_on_in SHALL be ignored.

Verification
REQ-036 Reset, load bank 0 width 8 from base 0x100, source valid 2 cycles after each req -> 8 reqs at 0x100..0x107, done_out once, busy_out 0 next cycle.
REQ-037 After REQ-036, osc 0 index 3 bank 0 -> osc_data_out[0] = source word 0x103 three edges after its slot; index 8 -> 0.
REQ-038 Load bank 1 while osc 1 plays bank 1 and osc 0 plays bank 0 -> osc 1 holds its value throughout, osc 0 keeps updating.
REQ-039 Trigger with width 0 -> no src_req_out, done_out 1 cycle later, bank reads all 0; trigger while busy -> ignored.
REQ-040 rst_in low in REQ state -> src_req_out and busy_out 0 immediately, all outputs 0; with WAVE_BANK_LOADER_GATE_OFF_EN, osc_is_on_in[2]=0 -> osc_data_out[2]=0.
